// File: rtl/seg7_pkg.sv
// Shared types and constants for the binary-to-decimal seven-segment display path.
package seg7_pkg;

  localparam int unsigned ITER_MAX = 16;
  localparam int unsigned ITER_W   = 5;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIB_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [NIB_W-1:0] bcd_nib_t;

  // Active-low segment codes, bit0=a .. bit6=g
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Double-dabble correction: a nibble of 5 or more would overflow decimal on the next shift
  function automatic bcd_nib_t add3(input bcd_nib_t n);
    return (n >= 4'd5) ? NIB_W'(n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder with blank override.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] i_digit,
  input  logic             i_blank,
  output logic [SEG_W-1:0] o_seg_c
);

  // Digit lookup; codes above 9 and forced blanks light nothing
  always_comb begin
    o_seg_c = SEG_BLANK;
    if (!i_blank) begin
      case (i_digit)
        4'd0:    o_seg_c = SEG_0;
        4'd1:    o_seg_c = SEG_1;
        4'd2:    o_seg_c = SEG_2;
        4'd3:    o_seg_c = SEG_3;
        4'd4:    o_seg_c = SEG_4;
        4'd5:    o_seg_c = SEG_5;
        4'd6:    o_seg_c = SEG_6;
        4'd7:    o_seg_c = SEG_7;
        4'd8:    o_seg_c = SEG_8;
        4'd9:    o_seg_c = SEG_9;
        default: o_seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_hex_display.sv
// Iterative double-dabble converter driving HEX0..HEX5 with the decimal value of a 16-bit input.
// Optional macro SEG7_LEADING_BLANK_EN blanks leading zero digits (digit0 always shown).
module bcd_hex_display
  import seg7_pkg::*;
#(
  parameter int unsigned BIN_W = 16,
  parameter int unsigned NDIG  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [NDIG*NIB_W-1:0] bcd_out,
  output logic [SEG_W-1:0]      hex0,
  output logic [SEG_W-1:0]      hex1,
  output logic [SEG_W-1:0]      hex2,
  output logic [SEG_W-1:0]      hex3,
  output logic [SEG_W-1:0]      hex4,
  output logic [SEG_W-1:0]      hex5
);

  localparam int unsigned BCD_W = NDIG * NIB_W;
  localparam int unsigned NSHOW = 5;

  state_t            r_state;
  logic [BIN_W-1:0]  r_bin;
  logic [BCD_W-1:0]  r_bcd;
  logic [ITER_W-1:0] r_iter;

  logic [BCD_W-1:0]  w_adj;
  logic [NSHOW-1:0]  w_blank;
  logic [SEG_W-1:0]  w_seg [NSHOW];

  // Add-3 correction applied to every accumulator nibble before the shift
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      w_adj[NIB_W*i +: NIB_W] = add3(r_bcd[NIB_W*i +: NIB_W]);
    end
  end

`ifdef SEG7_LEADING_BLANK_EN
  logic w_lead;

  // Blank a digit while it and every more significant digit are zero; units always shown
  always_comb begin
    w_blank = '0;
    w_lead  = 1'b1;
    for (int i = int'(NSHOW) - 1; i >= 1; i--) begin
      w_lead     = w_lead & (r_bcd[NIB_W*i +: NIB_W] == 4'd0);
      w_blank[i] = w_lead;
    end
  end
`else
  // All digits always shown
  always_comb begin
    w_blank = '0;
  end
`endif

  // One decoder per displayed digit, fed from the finished accumulator
  for (genvar g = 0; g < int'(NSHOW); g++) begin : g_dec
    seg7_decode u_dec (
      .i_digit (r_bcd[NIB_W*g +: NIB_W]),
      .i_blank (w_blank[g]),
      .o_seg_c (w_seg[g])
    );
  end

  // Conversion FSM: capture, 16 shift iterations, then publish result for one done cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_iter  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      hex0    <= SEG_BLANK;
      hex1    <= SEG_BLANK;
      hex2    <= SEG_BLANK;
      hex3    <= SEG_BLANK;
      hex4    <= SEG_BLANK;
      hex5    <= SEG_BLANK;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin   <= bin_in;
            r_bcd   <= '0;
            r_iter  <= '0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd  <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
          r_bin  <= {r_bin[BIN_W-2:0], 1'b0};
          r_iter <= ITER_W'(r_iter + 1'b1);
          if (r_iter == ITER_W'(ITER_MAX - 1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          bcd_out <= r_bcd;
          hex0    <= w_seg[0];
          hex1    <= w_seg[1];
          hex2    <= w_seg[2];
          hex3    <= w_seg[3];
          hex4    <= w_seg[4];
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
